// File: rtl/mdu_iterative.sv
// Multiply/divide unit with architectural HI/LO: counted-latency multiply,
// restoring divide (one quotient bit per cycle) followed by a sign-fixup cycle.
module mdu_iterative #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Handshake: a request is taken on a rising edge where start=1, flush=0 and
  // busy=0; a start seen while busy (or together with flush) is dropped.
  function automatic logic [2*WIDTH-1:0] mul_ext(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sgn);
    logic [2*WIDTH-1:0] ex;
    logic [2*WIDTH-1:0] ey;
    ex = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ey = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return ex * ey;
  endfunction

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_prod_now;
  logic [2*WIDTH-1:0] w_prod_lat;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_accept = start & ~flush & (r_state == S_IDLE);
  assign w_is_mul = (op == OP_MULT) | (op == OP_MULTU);
  assign w_is_div = (op == OP_DIV) | (op == OP_DIVU);

  // An unsigned W-bit magnitude already covers -MIN, so no extra bit is kept.
  assign w_a_neg  = (op == OP_DIV) & a[WIDTH-1];
  assign w_b_neg  = (op == OP_DIV) & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  assign w_prod_now = mul_ext(a, b, op == OP_MULT);
  assign w_prod_lat = mul_ext(r_a, r_b, r_signed);

  // Partial remainder stays below the divisor, so the difference fits W bits.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_sub      = w_shift[WIDTH-1:0] - r_dvs;
  assign w_rem_next = w_ge ? w_sub : w_shift[WIDTH-1:0];

  assign w_q_fix = r_neg_q ? -r_dvd : r_dvd;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              if (MUL_CYCLES == 1) begin
                {r_hi, r_lo} <= w_prod_now;
                r_done       <= 1'b1;
              end else begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= (op == OP_MULT);
                r_cnt    <= CW'(MUL_CYCLES - 1);
                r_state  <= S_MUL;
              end
            end else if (w_is_div) begin
              r_a     <= a;
              r_dvd   <= w_a_mag;
              r_dvs   <= w_b_mag;
              r_rem   <= '0;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_dz    <= (b == '0);
              r_cnt   <= CW'(WIDTH);
              r_state <= S_DIV;
            end else if (op == OP_MTHI) begin
              r_hi <= a;
            end else if (op == OP_MTLO) begin
              r_lo <= a;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_prod_lat;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_lo    <= r_dz ? '1 : w_q_fix;
            r_hi    <= r_dz ? r_a : w_r_fix;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: fixed vector table, hand-built flush/reset/busy
// sequences, and random operations checked against an arithmetic model.
module tb_mdu_iterative;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t vecs[10];

  mdu_iterative #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: plain 64-bit arithmetic, C-style truncating division.
  function automatic logic [63:0] ref_muldiv(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    res = '0;
    case (o)
      3'd0: res = sx * sy;
      3'd1: res = ux * uy;
      3'd2, 3'd3: begin
        if (y == 32'h0) begin
          res = {x, 32'hFFFF_FFFF};
        end else if (o == 3'd2) begin
          sq = sx / sy;
          sr = sx % sy;
          res = {sr[31:0], sq[31:0]};
        end else begin
          uq = ux / uy;
          ur = ux % uy;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // driver: issue one op at a negedge, then follow it to completion
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] e, input string tag);
    int k;
    bit busy_ok;
    logic [63:0] want;
    if (o <= 3'd3) exp_q.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    if (o > 3'd3) begin
      if (o == 3'd4) m_hi = x;
      else if (o == 3'd5) m_lo = x;
      chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
      chk({tag, "_busy_done"}, {62'b0, busy, done}, 64'b0);
      return;
    end
    k = 0;
    busy_ok = 1'b1;
    while (!done && k < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 64'(k), (o <= 3'd1) ? 64'(MUL_CYCLES) : 64'(WIDTH + 1));
    chk({tag, "_busy_during"}, {63'b0, busy_ok}, 64'd1);
    chk({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
    want = exp_q.pop_front();
    chk({tag, "_result"}, {hi, lo}, want);
    {m_hi, m_lo} = want;
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_no_done"}, {63'b0, seen}, 64'd0);
    chk({tag, "_hilo_kept"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    int k;
    resetn = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4] = '{3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[5] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[7] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{3'd1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};

    repeat (3) @(negedge clk);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_hilo", {hi, lo}, 64'd0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo},
            $sformatf("vec%0d", i));

    // flush mid-divide leaves the MTHI/MTLO values in place
    do_op(3'd4, 32'h0000_AAAA, 32'h0, 64'h0, "mthi");
    do_op(3'd5, 32'h0000_5555, 32'h0, 64'h0, "mtlo");
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_div_busy", {63'b0, busy}, 64'd0);
    chk("flush_div_hilo", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555});
    expect_quiet(40, "flush_div");

    // flush in the completion cycle wins over the write
    start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_prio_done", {63'b0, done}, 64'd0);
    chk("flush_prio_busy", {63'b0, busy}, 64'd0);
    expect_quiet(5, "flush_prio");

    // start with flush in IDLE is dropped; undefined op does nothing
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_hi", {32'b0, hi}, {32'b0, m_hi});
    do_op(3'd6, 32'h1234_5678, 32'h9, 64'h0, "undef6");
    expect_quiet(4, "undef");

    // second start while busy is ignored
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    op = 3'd2; a = 32'd100; b = 32'd7;
    k = 0;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("busy_start_latency", 64'(k), 64'(MUL_CYCLES));
    chk("busy_start_result", {hi, lo}, 64'd12);
    m_hi = 32'd0; m_lo = 32'd12;
    expect_quiet(40, "busy_start");

    // asynchronous reset mid-multiply
    do_op(3'd4, 32'h0000_1111, 32'h0, 64'h0, "mthi2");
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    expect_quiet(6, "rst_mid");

    // random operations, issued back-to-back on the done cycle
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;
      ro = 3'($urandom_range(0, 7));
      rx = pick();
      ry = pick();
      do_op(ro, rx, ry, ref_muldiv(ro, rx, ry), $sformatf("rnd%0d_op%0d", i, ro));
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
